// File: rtl/tl_memory_controller_master_if.sv
// ============================================================================
// Module   : tl_memory_controller_master_if
// Brief    : TileLink-UL channel A / channel D bundle between master and slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tl_memory_controller_master_if;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;

    logic [2:0]  d_opcode;
    logic [3:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_valid;
    logic        d_ready;

    modport master_ul (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
        input  a_ready,
        input  d_opcode, d_source, d_data, d_error, d_valid,
        output d_ready
    );

    modport slave_ul (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
        output a_ready,
        output d_opcode, d_source, d_data, d_error, d_valid,
        input  d_ready
    );
endinterface

`default_nettype wire

// File: rtl/tl_memory_controller_master.sv
// ============================================================================
// Module   : tl_memory_controller_master
// Brief    : Single-outstanding TileLink-UL master turning load/store requests
//            into Get / PutFullData and returning the channel-D result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_memory_controller_master #(
    parameter logic [3:0] SOURCE_ID = 4'd0
) (
    input  wire logic        clk_i,
    input  wire logic        reset_i,
    input  wire logic        req_valid,
    output logic             req_ready,
    input  wire logic        req_write,
    input  wire logic [31:0] req_addr,
    input  wire logic [1:0]  req_size,
    input  wire logic [31:0] req_wr_data,
    output logic             resp_valid,
    output logic [31:0]      resp_rd_data,
    output logic             resp_error,
    tl_memory_controller_master_if.master_ul tilelink
);

    localparam logic [1:0] c_SIZE_BYTE   = 2'd0;
    localparam logic [1:0] c_SIZE_HALF   = 2'd1;
    localparam logic [1:0] c_SIZE_WORD   = 2'd2;
    localparam logic [2:0] c_OP_PUT_FULL = 3'd0;
    localparam logic [2:0] c_OP_GET      = 3'd4;
    localparam logic [2:0] c_OP_ACK      = 3'd0;
    localparam logic [2:0] c_OP_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        WAIT_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q,  addr_d;
    logic [1:0]  size_q,  size_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] rd_q,    rd_d;
    logic        err_q,   err_d;

    logic        w_misaligned;
    logic        w_d_bad;

    // The reserved size encoding is rejected like a misaligned access.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            c_SIZE_BYTE: w_misaligned = 1'b0;
            c_SIZE_HALF: w_misaligned = req_addr[0];
            c_SIZE_WORD: w_misaligned = |req_addr[1:0];
            default:     w_misaligned = 1'b1;
        endcase
    end

    assign w_d_bad = tilelink.d_error
                   | (tilelink.d_source != SOURCE_ID)
                   | (tilelink.d_opcode != (write_q ? c_OP_ACK : c_OP_ACK_DATA));

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    data_d  = req_write ? req_wr_data : 32'd0;
                    rd_d    = 32'd0;
                    err_d   = w_misaligned;
                    state_d = w_misaligned ? RESP : SEND_A;
                end
            end
            SEND_A: begin
                if (tilelink.a_ready) state_d = WAIT_D;
            end
            WAIT_D: begin
                if (tilelink.d_valid) begin
                    err_d   = w_d_bad;
                    rd_d    = (!write_q && !w_d_bad) ? tilelink.d_data : 32'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every outward signal is a register or a pure decode of the state.
    always_comb begin
        tilelink.a_mask = 4'b1111;
        case (size_q)
            c_SIZE_BYTE: tilelink.a_mask = 4'b0001;
            c_SIZE_HALF: tilelink.a_mask = 4'b0011;
            default:     tilelink.a_mask = 4'b1111;
        endcase
    end

    assign req_ready          = reset_i && (state_q == IDLE);
    assign tilelink.a_valid   = (state_q == SEND_A);
    assign tilelink.a_opcode  = write_q ? c_OP_PUT_FULL : c_OP_GET;
    assign tilelink.a_param   = 3'd0;
    assign tilelink.a_size    = size_q;
    assign tilelink.a_source  = SOURCE_ID;
    assign tilelink.a_address = addr_q;
    assign tilelink.a_data    = data_q;
    assign tilelink.d_ready   = (state_q == WAIT_D);
    assign resp_valid         = (state_q == RESP);
    assign resp_rd_data       = rd_q;
    assign resp_error         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tl_memory_controller_master.sv
// ============================================================================
// Module   : tb_tl_memory_controller_master
// Brief    : Directed and randomized bench with a cycle-level slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl_memory_controller_master;

    localparam logic [3:0] c_SRC = 4'd3;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wr_data;
    logic        resp_valid;
    logic [31:0] resp_rd_data;
    logic        resp_error;

    int checks   = 0;
    int failures = 0;

    tl_memory_controller_master_if tl ();

    tl_memory_controller_master #(.SOURCE_ID(c_SRC)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_wr_data  (req_wr_data),
        .resp_valid   (resp_valid),
        .resp_rd_data (resp_rd_data),
        .resp_error   (resp_error),
        .tilelink     (tl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction; the slave stalls A for a_stall cycles and
    // answers D d_delay cycles into WAIT_D. fault: 1=source, 2=opcode, 3=d_error.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wd, input int a_stall, input int d_delay,
                       input int fault, input logic [31:0] dd);
        int          nbytes;
        logic        mis, eerr;
        logic [2:0]  eop;
        logic [3:0]  emask;
        logic [31:0] edata, erd;
        nbytes = 1 << size;
        mis    = (addr % nbytes) != 0;
        eop    = wr ? 3'd0 : 3'd4;
        emask  = 4'((1 << nbytes) - 1);
        edata  = wr ? wd : 32'd0;
        eerr   = mis || (fault != 0);
        erd    = (!wr && !eerr) ? dd : 32'd0;

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wr_data = wd;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_wr_data = $urandom;
        chk("req_ready_busy", req_ready, 0);
        if (!mis) begin
            for (int i = 0; i <= a_stall; i++) begin
                chk("a_valid", tl.a_valid, 1);
                chk("a_opcode", tl.a_opcode, eop);
                chk("a_param", tl.a_param, 0);
                chk("a_size", tl.a_size, size);
                chk("a_source", tl.a_source, c_SRC);
                chk("a_address", tl.a_address, addr);
                chk("a_mask", tl.a_mask, emask);
                chk("a_data", tl.a_data, edata);
                chk("d_ready_in_a", tl.d_ready, 0);
                chk("resp_valid_in_a", resp_valid, 0);
                tl.a_ready = (i == a_stall);
                @(negedge clk);
            end
            tl.a_ready = 1'b0;
            for (int i = 0; i <= d_delay; i++) begin
                chk("a_valid_after_fire", tl.a_valid, 0);
                chk("d_ready", tl.d_ready, 1);
                chk("resp_valid_in_d", resp_valid, 0);
                if (i == d_delay) begin
                    tl.d_valid  = 1'b1;
                    tl.d_data   = dd;
                    tl.d_source = (fault == 1) ? c_SRC + 4'd1 : c_SRC;
                    tl.d_error  = (fault == 3);
                    tl.d_opcode = ((fault == 2) ^ wr) ? 3'd0 : 3'd1;
                end
                @(negedge clk);
            end
            tl.d_valid = 1'b0;
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_error", resp_error, eerr);
        chk("resp_rd_data", resp_rd_data, erd);
        chk("a_valid_in_resp", tl.a_valid, 0);
        chk("req_ready_in_resp", req_ready, 0);
        @(negedge clk);
        chk("resp_valid_pulse", resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc, afire, nresp, resp1_cyc, acc2_cyc;
        bit          fire_req, last_wr;
        int          r, fault;
        logic [1:0]  sz;
        logic [31:0] ad;

        reset_i = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = '0; req_wr_data = '0;
        tl.a_ready = 1'b0; tl.d_valid = 1'b0; tl.d_opcode = '0;
        tl.d_source = '0; tl.d_data = '0; tl.d_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_valid", tl.a_valid, 0);
        chk("rst_d_ready", tl.d_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rd_data", resp_rd_data, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_req_ready", req_ready, 0);
        reset_i = 1'b1;
        @(negedge clk);

        txn(1'b0, 32'h100, 2'd2, 32'h0, 0, 0, 0, 32'hDEADBEEF);
        txn(1'b1, 32'h203, 2'd0, 32'h000000A5, 4, 1, 0, 32'h11223344);
        txn(1'b0, 32'h101, 2'd1, 32'h0, 0, 0, 0, 32'h0);
        chk("misaligned_no_a", tl.a_valid, 0);
        txn(1'b0, 32'h104, 2'd2, 32'h0, 0, 0, 1, 32'h55AA55AA);
        txn(1'b0, 32'h108, 2'd2, 32'h0, 1, 0, 2, 32'h66778899);
        txn(1'b0, 32'h10C, 2'd2, 32'h0, 0, 2, 3, 32'hABCDEF01);
        txn(1'b0, 32'h202, 2'd1, 32'h0, 2, 0, 0, 32'h0000BEEF);

        // Reset during WAIT_D abandons the load; a stale D beat is ignored.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_a_valid_pre", tl.a_valid, 1);
        tl.a_ready = 1'b1;
        @(negedge clk);
        tl.a_ready = 1'b0;
        chk("rstmid_d_ready_pre", tl.d_ready, 1);
        reset_i = 1'b0;
        @(negedge clk);
        chk("rstmid_a_valid", tl.a_valid, 0);
        chk("rstmid_d_ready", tl.d_ready, 0);
        chk("rstmid_resp_valid", resp_valid, 0);
        chk("rstmid_req_ready", req_ready, 0);
        reset_i = 1'b1;
        tl.d_valid = 1'b1; tl.d_opcode = 3'd1; tl.d_source = c_SRC; tl.d_data = 32'h12121212;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_stale_d_ready", tl.d_ready, 0);
            chk("rstmid_stale_resp", resp_valid, 0);
        end
        tl.d_valid = 1'b0;
        txn(1'b0, 32'h44, 2'd2, 32'h0, 0, 0, 0, 32'h0BADF00D);

        // Back-to-back: store then load with req_valid held high throughout.
        acc = 0; afire = 0; nresp = 0; resp1_cyc = -1; acc2_cyc = -1; last_wr = 1'b0;
        tl.a_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_size = 2'd2;
        req_wr_data = 32'h12345678;
        for (int cyc = 0; cyc < 20; cyc++) begin
            fire_req = req_valid && req_ready;
            if (tl.a_valid) last_wr = (tl.a_opcode == 3'd0);
            if (tl.a_valid && tl.a_ready) begin
                afire++;
                if (afire == 2) chk("b2b_a_address", tl.a_address, 32'h304);
            end
            if (resp_valid) begin
                nresp++;
                chk("b2b_req_ready_in_resp", req_ready, 0);
                if (nresp == 1) resp1_cyc = cyc;
                if (nresp == 2) chk("b2b_load_data", resp_rd_data, 32'hCAFEF00D);
            end
            tl.d_valid = tl.d_ready; tl.d_opcode = last_wr ? 3'd0 : 3'd1;
            tl.d_source = c_SRC; tl.d_data = 32'hCAFEF00D; tl.d_error = 1'b0;
            if (fire_req) begin
                acc++;
                if (acc == 2) acc2_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (fire_req) begin
                if (acc == 1) begin req_write = 1'b0; req_addr = 32'h304; end
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        tl.a_ready = 1'b0; tl.d_valid = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_a_fires", afire, 2);
        chk("b2b_resps", nresp, 2);
        chk("b2b_second_accept_cycle", acc2_cyc, resp1_cyc + 1);

        for (int n = 0; n < 24; n++) begin
            sz = 2'($urandom_range(0, 2));
            ad = $urandom;
            if ($urandom_range(0, 1) == 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            r = $urandom_range(0, 5);
            fault = (r < 3) ? 0 : r - 2;
            txn(1'($urandom), ad, sz, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 2), fault, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
